// File: rtl/pi_cmd_initiator.sv
// Initiator for the parallel dispense-command bus: presents state/amount, then runs a 4-phase strobe/ack handshake.
// Latency: bus valid 1 cycle after accept, candyflag SETUP_CYC cycles later; ack seen 2 cycles after the pin (synchronizer).
// Backpressure: cmd_ready is high only when idle; requests while busy are ignored, not queued.
module pi_cmd_initiator #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned TIMEOUT_CYC = 20800,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_state,
    input  logic [1:0] cmd_amount,
    output logic [2:0] teststate_o,
    output logic [1:0] amount_o,
    output logic       candyflag_o,
    input  logic       handshake_i,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       reject
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]       ts_q, ts_d;
    logic [1:0]       amt_q, amt_d;
    logic             flag_q, flag_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             reject_q, reject_d;
    logic             hs_meta_q, hs_meta_d;
    logic             hs_s_q, hs_s_d;

    // Next-state logic: handshake edges are tested before the terminal count so an ack on the last cycle still wins
    always_comb begin
        hs_meta_d = handshake_i;
        hs_s_d    = hs_meta_q;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        state_d   = state_q;
        cnt_d     = cnt_inc;
        ts_d      = ts_q;
        amt_d     = amt_q;
        flag_d    = flag_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        reject_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                flag_d = 1'b0;
                // ready is always high in IDLE, so cmd_valid alone is an accept here
                if (cmd_valid) begin
                    if (cmd_amount == 2'b11) begin
                        reject_d = 1'b1;
                    end else begin
                        ts_d    = cmd_state;
                        amt_d   = cmd_amount;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                    flag_d  = 1'b1;
                end
            end
            ST_REQ: begin
                if (hs_s_q) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    flag_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!hs_s_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                flag_d  = 1'b0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, bus and status registers; reset clears the strobe asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ts_q      <= 3'b000;
            amt_q     <= 2'b00;
            flag_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            reject_q  <= 1'b0;
            hs_meta_q <= 1'b0;
            hs_s_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ts_q      <= ts_d;
            amt_q     <= amt_d;
            flag_q    <= flag_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            reject_q  <= reject_d;
            hs_meta_q <= hs_meta_d;
            hs_s_q    <= hs_s_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign teststate_o = ts_q;
    assign amount_o    = amt_q;
    assign candyflag_o = flag_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign reject      = reject_q;

endmodule

// File: tb/tb_pi_cmd_initiator.sv
// Bench for pi_cmd_initiator: directed and random commands against a cycle-timeline reference model.
// The responder is played by the bench with chosen ack/release delays (or none).
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_pi_cmd_initiator;

    localparam int SETUP = 4;
    localparam int TMO   = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_state;
    logic [1:0] cmd_amount;
    logic [2:0] teststate_o;
    logic [1:0] amount_o;
    logic       candyflag_o;
    logic       handshake_i;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       reject;

    int vectors     = 0;
    int miscompares = 0;

    // reference copy of what the bus should currently show
    logic [2:0] m_ts;
    logic [1:0] m_am;

    always #5 clk = ~clk;

    pi_cmd_initiator #(
        .SETUP_CYC  (SETUP),
        .TIMEOUT_CYC(TMO),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_state  (cmd_state),
        .cmd_amount (cmd_amount),
        .teststate_o(teststate_o),
        .amount_o   (amount_o),
        .candyflag_o(candyflag_o),
        .handshake_i(handshake_i),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .reject     (reject)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic f, input logic b,
                           input logic d, input logic t, input logic r);
        chk({tag, " teststate"}, {29'd0, teststate_o}, {29'd0, m_ts});
        chk({tag, " amount"},    {30'd0, amount_o},    {30'd0, m_am});
        chk({tag, " candyflag"}, {31'd0, candyflag_o}, {31'd0, f});
        chk({tag, " busy"},      {31'd0, busy},        {31'd0, b});
        chk({tag, " cmd_ready"}, {31'd0, cmd_ready},   {31'd0, !b});
        chk({tag, " done"},      {31'd0, done},        {31'd0, d});
        chk({tag, " timeout"},   {31'd0, timeout},     {31'd0, t});
        chk({tag, " reject"},    {31'd0, reject},      {31'd0, r});
    endtask

    // One command. d1: cycles after the strobe rises before the responder raises its ack (<0 = never).
    // d2: cycles after the strobe falls before the responder drops its ack (<0 = holds it).
    // The ack needs 2 cycles through the synchronizer plus the decision edge, hence the +3.
    task automatic run_cmd(input int id, input logic [2:0] st, input logic [1:0] am,
                           input int d1, input int d2, input bit junk);
        bit rej, acked, rel_ok;
        int fall_k, end_k, last_k;
        logic hs;
        string tag;
        rej    = (am == 2'b11);
        acked  = (d1 >= 0) && (d1 + 3 <= TMO);
        rel_ok = acked && (d2 >= 0) && (d2 + 3 <= TMO);
        fall_k = SETUP + (acked ? d1 + 3 : TMO);
        end_k  = !acked ? fall_k : fall_k + (rel_ok ? d2 + 3 : TMO);
        last_k = rej ? 2 : end_k + 3;

        cmd_valid  = 1'b1;
        cmd_state  = st;
        cmd_amount = am;
        @(posedge clk);
        if (!rej) begin
            m_ts = st;
            m_am = am;
        end
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            if (junk && !rej && k < end_k) begin
                cmd_valid  = 1'b1;
                cmd_state  = ~st;
                cmd_amount = ~am;
            end else begin
                cmd_valid = 1'b0;
            end
            hs = 1'b0;
            if (!rej && acked && k >= SETUP + d1)
                hs = (d2 >= 0) ? (k < fall_k + d2) : (k < end_k);
            handshake_i = hs;
            @(negedge clk);
            tag = $sformatf("cmd%0d k=%0d", id, k);
            chk_all(tag,
                    !rej && k >= SETUP && k < fall_k,
                    !rej && k < end_k,
                    !rej && rel_ok && k == end_k,
                    !rej && !rel_ok && k == end_k,
                    rej && k == 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d1, d2;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_state   = 3'b000;
        cmd_amount  = 2'b00;
        handshake_i = 1'b0;
        m_ts        = 3'b000;
        m_am        = 2'b00;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all("post-reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // normal handshake, illegal amount, no ack, ack held high
        run_cmd(1, 3'b011, 2'b01, 3, 3, 1'b0);
        run_cmd(2, 3'b101, 2'b11, -1, -1, 1'b0);
        run_cmd(3, 3'b110, 2'b10, -1, -1, 1'b0);
        run_cmd(4, 3'b001, 2'b00, 5, -1, 1'b0);
        // ack / release arriving on the terminal-count cycle: handshake wins
        run_cmd(5, 3'b100, 2'b10, TMO - 3, 2, 1'b0);
        run_cmd(6, 3'b111, 2'b01, 1, TMO - 3, 1'b0);
        run_cmd(7, 3'b000, 2'b00, 0, 0, 1'b0);
        // new requests held while busy must be ignored
        run_cmd(8, 3'b010, 2'b01, 10, 4, 1'b1);

        // random traffic
        for (int n = 0; n < 20; n++) begin
            d1 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO - 3));
            d2 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO - 3));
            run_cmd(100 + n, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    d1, d2, 1'($urandom_range(0, 1)));
        end

        // reset while the strobe is up
        cmd_valid  = 1'b1;
        cmd_state  = 3'b111;
        cmd_amount = 2'b10;
        @(posedge clk);
        m_ts = 3'b111;
        m_am = 2'b10;
        #1 cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("midreq flag up", {31'd0, candyflag_o}, 32'd1);
        rst = 1'b1;
        #1;
        m_ts = 3'b000;
        m_am = 2'b00;
        chk_all("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all("after reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(200, 3'b101, 2'b00, 2, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
